chacha_ise_seq: RTL
===================

Name: chacha_ise_seq

Overview:
- Sequencer that computes one ChaCha block function by driving the ChaCha ISE datapath externally, one half-quarter-round op per cycle.
- Holds the 16-word working state and a copy of the input state.
- Issues the ad0/bc0/ad1/bc1 op sequence with packed operands, writes results back, and applies the final feed-forward add.
- Sits directly upstream of the ISE datapath and consumes its rd result in the same cycle.

Parameters:
ROUNDS, 20, number of ChaCha rounds; must be even and at least 2 (8/12/20 supported); ROUNDS/2 double rounds.

Ports:
g_clk  input  1  clock, all state updates on rising edge
g_rst  input  1  synchronous active-high reset
in_valid  input  1  input state offered
in_ready  output  1  block idle, accepts input
in_state  input  512  initial ChaCha state, word i at bits [32i+31:32i]
out_valid  output  1  keystream block available
out_ready  input  1  consumer accepts keystream
out_block  output  512  working state + input state per word (mod 2^32), same packing
ise_rs1  output  64  {a,d} operand to ISE
ise_rs2  output  64  {b,c} operand to ISE
ise_op_ad0  output  1  select ad, rotate 16
ise_op_bc0  output  1  select bc, rotate 12
ise_op_ad1  output  1  select ad, rotate 8
ise_op_bc1  output  1  select bc, rotate 7
ise_rd  input  64  ISE result, combinational from ise_rs1/ise_rs2/op strobes

Behaviour:
- Clock and reset: one clock g_clk; g_rst synchronous, active-high.
- States: IDLE, RUN, FF, DONE.
- Reset, or g_rst asserted at any point mid-operation, takes effect at the next edge:
  - state IDLE, all counters 0, working and saved state 0;
  - out_valid 0, out_block 0, all op strobes 0, ise_rs1/ise_rs2 0;
  - in_ready is 1 from the first cycle after reset.
- in_ready = (state==IDLE). in_valid while not IDLE is ignored and in_state is not sampled.
- IDLE: on in_valid && in_ready, latch in_state into both working and saved registers; clear counters; go to RUN.
- RUN counters:
  - op_cnt (2b): 0=ad0, 1=bc0, 2=ad1, 3=bc1.
  - qr_cnt (3b): 0-3 column QRs, 4-7 diagonal QRs.
  - dr_cnt counts double rounds 0..ROUNDS/2-1.
- Quarter-round word indices (a,b,c,d):
  - columns: (0,4,8,12) (1,5,9,13) (2,6,10,14) (3,7,11,15);
  - diagonals: (0,5,10,15) (1,6,11,12) (2,7,8,13) (3,4,9,14).
- Each RUN cycle:
  - drive ise_rs1={w[a],w[d]}, ise_rs2={w[b],w[c]}; exactly one op strobe high, per op_cnt.
  - ad ops: write ise_rd[63:32]->w[a], ise_rd[31:0]->w[d].
  - bc ops: write ise_rd[63:32]->w[b], ise_rd[31:0]->w[c].
- Counter wrap: op_cnt 3->0 increments qr_cnt; qr_cnt 7->0 increments dr_cnt. Last op of last double round goes to FF.
- RUN lasts exactly 16*ROUNDS cycles (320 for ROUNDS=20).
- Op strobes are mutually exclusive and low outside RUN; ise_rs1/ise_rs2 are 0 outside RUN.
- FF (1 cycle): out_block word i <= w[i]+saved[i] mod 2^32, registered; go to DONE.
- DONE: out_valid=1, out_block stable until out_ready. On handshake return to IDLE; out_valid 0 next cycle.
- out_ready while not DONE has no effect.
- Total latency from input handshake edge to out_valid high: 16*ROUNDS+2 cycles.
- Back-to-back: in_ready rises the cycle after the output handshake; no overlap of blocks.

Optional Feature:
CHACHA_SEQ_ZEROISE_EN
- Defined: on the output handshake edge, working state, saved state and out_block registers are cleared to 0 (key material erased). out_block reads 0 in IDLE.
- Undefined: registers retain their last values after the handshake; out_block keeps its last result until the next FF.
- All other timing is identical in both builds.

Test Plan:
- Reset: assert g_rst 2 cycles mid-RUN -> next cycle in_ready=1, out_valid=0, all op strobes 0, ise_rs1=ise_rs2=0.
- First ops: load words w[i]=i, hold ise_rd={rs1 hi+1, rs1 lo+1} from a bench model -> cycle 1 ise_op_ad0=1, ise_rs1=0x00000000_0000000C, ise_rs2=0x00000004_00000008; cycle 2 ise_op_bc0=1, ise_rs1={1,0xD}, ise_rs2={4,8}.
- Known answer: connect the real ISE; load the 20-round block-function vector (constants 61707865 3320646e 79622d32 6b206574, key 03020100..1f1e1d1c, counter 1, nonce 09000000 4a000000 00000000) -> out_valid exactly 322 cycles after the input handshake, out_block word0=0xe4e7f110.
- Backpressure: hold out_ready=0 for 50 cycles in DONE -> out_valid stays 1, out_block unchanged, in_ready=0, in_valid ignored; then out_ready=1 -> IDLE next cycle.
- ROUNDS=8 build: same vector -> out_valid after 130 cycles; op strobe count ad0=bc0=ad1=bc1=32.
- CHACHA_SEQ_ZEROISE_EN build: after output handshake, out_block==0 and a following run with in_state all-zero yields the all-zero-key block, showing no residue from the previous block.

Source files
------------

// File: rtl/chacha_ise_seq.sv
// ---------------------------------------------------------------------------
// chacha_ise_seq
//
// Computes one ChaCha block function by steering an external ChaCha ISE
// datapath. One half-quarter-round op is issued per cycle: the {a,d} and
// {b,c} word pairs go out on ise_rs1/ise_rs2 together with one op strobe,
// and the combinational ise_rd result is written back on the same edge.
// After ROUNDS rounds the input state is added back in (feed-forward) and
// the keystream block is held until the consumer takes it.
//
// Ports
//   g_clk, g_rst        clock, synchronous active-high reset
//   in_valid/in_ready   input handshake; in_state is the 16-word start state
//                       (word i at bits [32i+31:32i])
//   out_valid/out_ready output handshake; out_block is the keystream block
//   ise_rs1, ise_rs2    {w[a],w[d]} and {w[b],w[c]} operands to the ISE
//   ise_op_ad0..bc1     one-hot op select (ad/rot16, bc/rot12, ad/rot8,
//                       bc/rot7), all low outside RUN
//   ise_rd              ISE result, combinational from the operands
//
// Parameter
//   ROUNDS              ChaCha rounds, even and >= 2 (8/12/20)
//
// Build option
//   CHACHA_SEQ_ZEROISE_EN  when defined, working state, saved state and
//                          out_block are cleared on the output handshake.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for an input block, in_ready high
// RUN   | issuing ise ops, 16*ROUNDS cycles
// FF    | one cycle, out_block <= working + saved
// DONE  | out_valid high, waiting for out_ready
// ---------------------------------------------------------------------------
module chacha_ise_seq #(
    parameter int ROUNDS = 20
) (
    input  logic         g_clk,
    input  logic         g_rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] out_block,
    output logic [63:0]  ise_rs1,
    output logic [63:0]  ise_rs2,
    output logic         ise_op_ad0,
    output logic         ise_op_bc0,
    output logic         ise_op_ad1,
    output logic         ise_op_bc1,
    input  logic [63:0]  ise_rd
);

    localparam int DR_NUM = ROUNDS / 2;
    localparam int DRW    = (DR_NUM > 1) ? $clog2(DR_NUM) : 1;
    localparam logic [DRW-1:0] DR_LAST = DRW'(DR_NUM - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FF   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state;
    logic [1:0]      op_cnt;
    logic [2:0]      qr_cnt;
    logic [DRW-1:0]  dr_cnt;
    logic [31:0]     w     [16];
    logic [31:0]     saved [16];

    logic [3:0]      idx_a;
    logic [3:0]      idx_b;
    logic [3:0]      idx_c;
    logic [3:0]      idx_d;
    logic [1:0]      qi;
    logic            diag;
    logic            running;

    // Quarter-round word selection. Columns use (q, 4+q, 8+q, 12+q); the
    // diagonals rotate the b/c/d rows by 1/2/3 positions, which is just a
    // 2-bit add on the column index.
    always_comb begin
        qi    = qr_cnt[1:0];
        diag  = qr_cnt[2];
        idx_a = {2'b00, qi};
        idx_b = {2'b01, qi + {1'b0, diag}};
        idx_c = {2'b10, qi + {diag, 1'b0}};
        idx_d = {2'b11, qi + {diag, diag}};
    end

    assign running   = (state == RUN);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Operands and strobes are decoded from registered state so ise_rd is
    // available to write back on the same edge.
    always_comb begin
        ise_rs1    = 64'd0;
        ise_rs2    = 64'd0;
        ise_op_ad0 = 1'b0;
        ise_op_bc0 = 1'b0;
        ise_op_ad1 = 1'b0;
        ise_op_bc1 = 1'b0;
        if (running) begin
            ise_rs1    = {w[idx_a], w[idx_d]};
            ise_rs2    = {w[idx_b], w[idx_c]};
            ise_op_ad0 = (op_cnt == 2'd0);
            ise_op_bc0 = (op_cnt == 2'd1);
            ise_op_ad1 = (op_cnt == 2'd2);
            ise_op_bc1 = (op_cnt == 2'd3);
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_rst) begin
            state     <= IDLE;
            op_cnt    <= 2'd0;
            qr_cnt    <= 3'd0;
            dr_cnt    <= '0;
            out_block <= '0;
            for (int i = 0; i < 16; i++) begin
                w[i]     <= 32'd0;
                saved[i] <= 32'd0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < 16; i++) begin
                            w[i]     <= in_state[32*i +: 32];
                            saved[i] <= in_state[32*i +: 32];
                        end
                        op_cnt <= 2'd0;
                        qr_cnt <= 3'd0;
                        dr_cnt <= '0;
                        state  <= RUN;
                    end
                end

                RUN: begin
                    // op_cnt[0]==0 are the ad ops (ad0, ad1)
                    if (!op_cnt[0]) begin
                        w[idx_a] <= ise_rd[63:32];
                        w[idx_d] <= ise_rd[31:0];
                    end else begin
                        w[idx_b] <= ise_rd[63:32];
                        w[idx_c] <= ise_rd[31:0];
                    end

                    op_cnt <= op_cnt + 2'd1;
                    if (op_cnt == 2'd3) begin
                        qr_cnt <= qr_cnt + 3'd1;
                        if (qr_cnt == 3'd7) begin
                            if (dr_cnt == DR_LAST) begin
                                dr_cnt <= '0;
                                state  <= FF;
                            end else begin
                                dr_cnt <= dr_cnt + 1'b1;
                            end
                        end
                    end
                end

                FF: begin
                    for (int i = 0; i < 16; i++) begin
                        out_block[32*i +: 32] <= w[i] + saved[i];
                    end
                    state <= DONE;
                end

                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
`ifdef CHACHA_SEQ_ZEROISE_EN
                        // erase key material once the block has been taken
                        out_block <= '0;
                        for (int i = 0; i < 16; i++) begin
                            w[i]     <= 32'd0;
                            saved[i] <= 32'd0;
                        end
`else
                        out_block <= out_block;
`endif
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
